fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-domain pointer and flag stage for the async FIFO. It sits directly upstream of the pseudo-dual-port storage RAM.
- Generates the binary write pointer and the RAM write address, plus the Gray write pointer that is sent to the read domain.
- Synchronises the read-domain Gray pointer into wclk.
- Produces the registered full flag and a fill level, both consumed by the RAM write port and by the producer.

Parameters:
- d_width, 8, data width; unused internally, kept for a uniform FIFO parameter set.
- depth, 8, number of RAM entries; power of 2, minimum 4. ADDR = $clog2(depth).
- SYNC_STAGES, 2, flop stages on the incoming read Gray pointer; minimum 2.
- AF_THRESH, depth-2, fill level at or above which almost_full asserts (optional feature only).

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  synchronous, active-high reset (wclk domain).
- w_en  in  1  producer write request.
- rptr_gray_async  in  ADDR+1  read-domain Gray pointer, asynchronous to wclk.
- bin_w_ptr  out  ADDR+1  binary write pointer; bit ADDR is the wrap bit.
- ram_w_addr  out  ADDR+1  {1'b0, bin_w_ptr[ADDR-1:0]}; drives the RAM write-pointer input.
- gray_w_ptr  out  ADDR+1  registered Gray code of bin_w_ptr, sent to the read domain.
- full  out  1  registered full flag; also drives the RAM full input.
- w_level  out  ADDR+1  registered fill level as seen from the write domain, range 0..depth.
- almost_full  out  1  see Optional Feature.

Behaviour:
- **Reset** (wrst high at a wclk edge), all at the same edge:
  - bin_w_ptr, gray_w_ptr, ram_w_addr = 0.
  - All synchroniser flops = 0.
  - full = 0, w_level = 0, almost_full = 0.
  - Reset mid-operation discards all state at that edge. The read domain is reset independently and is not touched by this block.
- **Accept:** wacc = w_en & ~full, using the registered full. This is the same qualification the RAM applies, so RAM and pointer never disagree.
- **Pointer update:** bin_next = bin_w_ptr + wacc, modulo 2^(ADDR+1) with natural wrap; no saturation. gray_next = bin_next ^ (bin_next >> 1). Both are registered each cycle.
- **Latency:**
  - ram_w_addr reflects the slot for the next write in the same cycle bin_w_ptr updates.
  - The RAM samples data at the wacc edge using the pre-update address.
- **Synchroniser:**
  - rptr_gray_async passes through SYNC_STAGES flops; the last stage is rq_sync.
  - Only Gray values cross the domain; no binary value crosses.
  - rbin_sync = gray2bin(rq_sync), combinational XOR prefix.
- **Full:**
  - full <= (gray_next == {~rq_sync[ADDR:ADDR-1], rq_sync[ADDR-2:0]}).
  - Full therefore asserts on the edge that accepts the depth-th outstanding write, i.e. it is visible the cycle after that write.
  - Deassertion is pessimistic: at least SYNC_STAGES+1 cycles after the read pointer moves.
- **Level:**
  - w_level <= bin_next - rbin_sync, ADDR+1-bit modulo subtraction.
  - Invariant: full == (w_level == depth).
  - w_level never exceeds depth.
- **Simultaneous events:** w_en while full has no effect on any state. A read-pointer change and a write in the same cycle are both reflected at the next edge.
- **Wrap-around:** after 2^(ADDR+1) accepted writes, bin_w_ptr returns to 0; the wrap bit toggles every depth writes.

Optional Feature:
- Macro: FIFO_ALMOST_FULL_EN.
- Defined: almost_full <= (w_level_next >= AF_THRESH), registered on the same basis as full, and cleared on reset.
- Undefined: almost_full is tied to 0 and no comparator logic is generated.

Test Plan:
- depth=8, hold rptr_gray_async=0, w_en=1 for 10 cycles:
  - 8 writes accepted, then full=1 and w_level=8.
  - bin_w_ptr=4'b1000, gray_w_ptr=4'b1100, ram_w_addr=0.
  - Writes 9–10 ignored; pointer unchanged.
- From full, set rptr_gray_async=4'b0010 (read ptr 3):
  - full stays 1 for exactly SYNC_STAGES cycles.
  - Next edge: full=0 and w_level=5.
  - Then 3 writes refill to full; bin_w_ptr=4'b1011.
- Free-running: reads track writes, 20 accepted writes:
  - bin_w_ptr wraps 15 -> 0 and ends at 4.
  - Each gray_w_ptr step changes exactly 1 bit.
  - ram_w_addr sequence is 0..7 repeating.
- Assert wrst for one cycle after 5 writes with w_en held high:
  - Next cycle all outputs = 0.
  - The first post-reset write lands at ram_w_addr=0.
- With FIFO_ALMOST_FULL_EN and AF_THRESH=6, read ptr held at 0:
  - almost_full rises with w_level=6 and stays high through full.
  - With the macro undefined, almost_full is 0 throughout.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Async FIFO write side: binary/Gray write pointer, read-pointer synchroniser, full flag and fill level.
// Latency: pointer, full and level update on the accepting edge; read-pointer moves appear after SYNC_STAGES+1 edges.
// Backpressure: a write is taken only when w_en is high and the registered full is low. almost_full needs FIFO_ALMOST_FULL_EN.
module fifo_wptr_full #(
    parameter int d_width     = 8,
    parameter int depth       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = depth - 2,
    localparam int ADDR       = $clog2(depth)
) (
    input  logic            wclk,
    input  logic            wrst,
    input  logic            w_en,
    input  logic [ADDR:0]   rptr_gray_async,
    output logic [ADDR:0]   bin_w_ptr,
    output logic [ADDR:0]   ram_w_addr,
    output logic [ADDR:0]   gray_w_ptr,
    output logic            full,
    output logic [ADDR:0]   w_level,
    output logic            almost_full
);

    if (d_width < 1 || depth < 4 || (depth & (depth - 1)) != 0 || SYNC_STAGES < 2 ||
        AF_THRESH < 0 || AF_THRESH > depth) begin : g_param_check
        $error("fifo_wptr_full: illegal parameter set");
    end

    logic [ADDR:0] bin_q, bin_d;
    logic [ADDR:0] gray_q, gray_d;
    logic          full_q, full_d;
    logic [ADDR:0] level_q, level_d;
    logic [ADDR:0] sync_q [SYNC_STAGES];
    logic [ADDR:0] rq_sync;
    logic [ADDR:0] rbin_sync;
    logic          wacc;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rq_sync = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i <= ADDR; i++) rbin_sync[i] = ^(rq_sync >> i);
    end

    always_comb begin
        wacc    = w_en & ~full_q;
        bin_d   = bin_q + (ADDR+1)'(wacc);
        gray_d  = bin_d ^ (bin_d >> 1);
        full_d  = (gray_d == {~rq_sync[ADDR:ADDR-1], rq_sync[ADDR-2:0]});
        level_d = bin_d - rbin_sync;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            level_q <= level_d;
        end
    end

    assign bin_w_ptr  = bin_q;
    assign ram_w_addr = {1'b0, bin_q[ADDR-1:0]};
    assign gray_w_ptr = gray_q;
    assign full       = full_q;
    assign w_level    = level_q;

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [ADDR:0] AF_LVL = (ADDR+1)'(AF_THRESH);
    logic af_q;

    always_ff @(posedge wclk) begin
        if (wrst) af_q <= 1'b0;
        else      af_q <= (level_d >= AF_LVL);
    end

    assign almost_full = af_q;
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (depth 8, two sync stages) against a pointer-count reference model.
module tb_fifo_wptr_full;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int AFT   = DEPTH - 2;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       w_en = 1'b0;
    logic [3:0] rptr_gray_async;
    logic [3:0] bin_w_ptr, ram_w_addr, gray_w_ptr, w_level;
    logic       full, almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: total accepted writes, the reader's binary pointer and its delayed view.
    int   rd_bin  = 0;
    int   m_wr    = 0;
    int   m_level = 0;
    bit   m_full  = 1'b0;
    bit   m_af    = 1'b0;
    int   rd_hist[$];

    fifo_wptr_full #(.d_width(8), .depth(DEPTH), .SYNC_STAGES(SYNC), .AF_THRESH(AFT)) dut (
        .wclk(wclk), .wrst(wrst), .w_en(w_en), .rptr_gray_async(rptr_gray_async),
        .bin_w_ptr(bin_w_ptr), .ram_w_addr(ram_w_addr), .gray_w_ptr(gray_w_ptr),
        .full(full), .w_level(w_level), .almost_full(almost_full)
    );

    always #5 wclk = ~wclk;

    assign rptr_gray_async = 4'(rd_bin ^ (rd_bin >> 1));

    function automatic logic [3:0] to_gray(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic tick();
        int seen;
        bit acc;
        @(posedge wclk);
        if (wrst) begin
            m_wr = 0; m_level = 0; m_full = 1'b0; m_af = 1'b0;
            rd_hist.delete();
        end else begin
            acc = w_en && !m_full;
            rd_hist.push_back(rd_bin);
            seen    = (rd_hist.size() > SYNC) ? rd_hist[rd_hist.size()-1-SYNC] : 0;
            m_wr    = (m_wr + int'(acc)) % 16;
            m_level = (m_wr - seen) & 15;
            m_full  = (m_level == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
            m_af    = (m_level >= AFT);
`else
            m_af    = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1; w_en = 1'b0; rd_bin = 0;
        tick();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bin_w_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_bin got=%0d exp=0", bin_w_ptr); end
        n_checks++; if (gray_w_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_gray got=%0d exp=0", gray_w_ptr); end
        n_checks++; if (ram_w_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", ram_w_addr); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full); end
        n_checks++; if (w_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", w_level); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
    endtask

    task automatic test_fill();
        do_reset();
        w_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (bin_w_ptr !== 4'(m_wr)) begin n_fail++; $display("FAIL fill_bin cyc=%0d got=%0d exp=%0d", i, bin_w_ptr, m_wr); end
            n_checks++; if (full !== m_full) begin n_fail++; $display("FAIL fill_full cyc=%0d got=%0b exp=%0b", i, full, m_full); end
            n_checks++; if (w_level !== 4'(m_level)) begin n_fail++; $display("FAIL fill_level cyc=%0d got=%0d exp=%0d", i, w_level, m_level); end
            n_checks++; if (almost_full !== m_af) begin n_fail++; $display("FAIL fill_af cyc=%0d got=%0b exp=%0b", i, almost_full, m_af); end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full_end got=%0b exp=1", full); end
        n_checks++; if (w_level !== 4'd8) begin n_fail++; $display("FAIL fill_level_end got=%0d exp=8", w_level); end
        n_checks++; if (bin_w_ptr !== 4'b1000) begin n_fail++; $display("FAIL fill_bin_end got=%b exp=1000", bin_w_ptr); end
        n_checks++; if (gray_w_ptr !== 4'b1100) begin n_fail++; $display("FAIL fill_gray_end got=%b exp=1100", gray_w_ptr); end
        n_checks++; if (ram_w_addr !== 4'd0) begin n_fail++; $display("FAIL fill_addr_end got=%0d exp=0", ram_w_addr); end
`ifdef FIFO_ALMOST_FULL_EN
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_end got=%0b exp=1", almost_full); end
`else
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_end got=%0b exp=0", almost_full); end
`endif
        w_en = 1'b0;
    endtask

    task automatic test_drain_refill();
        rd_bin = 3;
        for (int i = 1; i <= SYNC; i++) begin
            tick();
            n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL drain_hold cyc=%0d got=%0b exp=1", i, full); end
        end
        tick();
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL drain_release got=%0b exp=0", full); end
        n_checks++; if (w_level !== 4'd5) begin n_fail++; $display("FAIL drain_level got=%0d exp=5", w_level); end
        w_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (full !== m_full) begin n_fail++; $display("FAIL refill_full cyc=%0d got=%0b exp=%0b", i, full, m_full); end
            n_checks++; if (w_level !== 4'(m_level)) begin n_fail++; $display("FAIL refill_level cyc=%0d got=%0d exp=%0d", i, w_level, m_level); end
        end
        n_checks++; if (bin_w_ptr !== 4'b1011) begin n_fail++; $display("FAIL refill_bin got=%b exp=1011", bin_w_ptr); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL refill_full_end got=%0b exp=1", full); end
        w_en = 1'b0;
    endtask

    task automatic test_wrap();
        int accepted = 0;
        int cycles = 0;
        bit wrapped = 1'b0;
        logic [3:0] prev_gray, prev_bin;
        do_reset();
        w_en = 1'b1;
        while (accepted < 20 && cycles < 100) begin
            prev_gray = gray_w_ptr;
            prev_bin  = bin_w_ptr;
            tick();
            cycles++;
            if (bin_w_ptr !== prev_bin) begin
                accepted++;
                if (prev_bin == 4'd15 && bin_w_ptr == 4'd0) wrapped = 1'b1;
                n_checks++; if ($countones(gray_w_ptr ^ prev_gray) != 1) begin n_fail++; $display("FAIL wrap_gray_step got=%b prev=%b exp=one_bit_change", gray_w_ptr, prev_gray); end
                n_checks++; if (gray_w_ptr !== to_gray(accepted % 16)) begin n_fail++; $display("FAIL wrap_gray got=%b exp=%b", gray_w_ptr, to_gray(accepted % 16)); end
                n_checks++; if (ram_w_addr !== 4'(accepted % 8)) begin n_fail++; $display("FAIL wrap_addr got=%0d exp=%0d", ram_w_addr, accepted % 8); end
            end
            rd_bin = m_wr;
        end
        n_checks++; if (accepted != 20) begin n_fail++; $display("FAIL wrap_timeout got=%0d exp=20", accepted); end
        n_checks++; if (bin_w_ptr !== 4'd4) begin n_fail++; $display("FAIL wrap_bin_end got=%0d exp=4", bin_w_ptr); end
        n_checks++; if (!wrapped) begin n_fail++; $display("FAIL wrap_seen got=0 exp=1"); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full got=%0b exp=0", full); end
        w_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        w_en = 1'b1;
        repeat (5) tick();
        n_checks++; if (bin_w_ptr !== 4'd5) begin n_fail++; $display("FAIL mid_pre_bin got=%0d exp=5", bin_w_ptr); end
        wrst = 1'b1; rd_bin = 0;
        tick();
        wrst = 1'b0;
        n_checks++; if ({bin_w_ptr, gray_w_ptr, ram_w_addr, w_level} !== 16'd0) begin n_fail++; $display("FAIL mid_ptrs got=%h exp=0", {bin_w_ptr, gray_w_ptr, ram_w_addr, w_level}); end
        n_checks++; if ({full, almost_full} !== 2'b00) begin n_fail++; $display("FAIL mid_flags got=%b exp=00", {full, almost_full}); end
        tick();
        n_checks++; if (bin_w_ptr !== 4'd1) begin n_fail++; $display("FAIL mid_first_bin got=%0d exp=1", bin_w_ptr); end
        n_checks++; if (ram_w_addr !== 4'd1) begin n_fail++; $display("FAIL mid_first_addr got=%0d exp=1", ram_w_addr); end
        w_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            w_en = ($urandom_range(0, 3) != 0);
            if (((m_wr - rd_bin) & 15) != 0 && $urandom_range(0, 2) == 0) rd_bin = (rd_bin + 1) & 15;
            if ($urandom_range(0, 149) == 0) begin wrst = 1'b1; rd_bin = 0; end
            tick();
            wrst = 1'b0;
            n_checks++; if (bin_w_ptr !== 4'(m_wr)) begin n_fail++; $display("FAIL rnd_bin cyc=%0d got=%0d exp=%0d", i, bin_w_ptr, m_wr); end
            n_checks++; if (gray_w_ptr !== to_gray(m_wr)) begin n_fail++; $display("FAIL rnd_gray cyc=%0d got=%b exp=%b", i, gray_w_ptr, to_gray(m_wr)); end
            n_checks++; if (ram_w_addr !== 4'(m_wr % 8)) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", i, ram_w_addr, m_wr % 8); end
            n_checks++; if (full !== m_full) begin n_fail++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", i, full, m_full); end
            n_checks++; if (w_level !== 4'(m_level)) begin n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, w_level, m_level); end
            n_checks++; if (almost_full !== m_af) begin n_fail++; $display("FAIL rnd_af cyc=%0d got=%0b exp=%0b", i, almost_full, m_af); end
            n_checks++; if (full !== (w_level == 4'd8) || w_level > 4'd8) begin n_fail++; $display("FAIL rnd_invariant cyc=%0d full=%0b level=%0d exp=full_iff_level8", i, full, w_level); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_refill();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
